// File: rtl/psum_accumulator_pkg.sv
// Shared constants, row types and the saturating accumulate helper for the
// partial-sum accumulator that follows the systolic array.
package psum_accumulator_pkg;

    localparam int SYS_COLS     = 3;
    localparam int P_BITWIDTH   = 32;
    localparam int ACC_BITWIDTH = P_BITWIDTH + 8;
    localparam int A_BITWIDTH   = 8;
    localparam int ACC_DEPTH    = 16;
    localparam int ROWS_W       = $clog2(ACC_DEPTH + 1);
    localparam int ROW_W        = $clog2(ACC_DEPTH);

    typedef logic signed [ACC_BITWIDTH-1:0] acc_t;
    typedef logic signed [A_BITWIDTH-1:0]   act_t;

    typedef logic [SYS_COLS-1:0][P_BITWIDTH-1:0]   psum_row_t;
    typedef logic [SYS_COLS-1:0][ACC_BITWIDTH-1:0] acc_row_t;
    typedef logic [SYS_COLS-1:0][A_BITWIDTH-1:0]   act_row_t;

    localparam acc_t ACC_MAX = {1'b0, {(ACC_BITWIDTH-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACC_BITWIDTH-1){1'b0}}};

    function automatic acc_t sext_psum(input logic [P_BITWIDTH-1:0] p);
        return {{(ACC_BITWIDTH-P_BITWIDTH){p[P_BITWIDTH-1]}}, p};
    endfunction

    // One guard bit is enough to detect overflow of a two-operand add.
    function automatic acc_t sat_add(input acc_t a, input acc_t b);
        logic [ACC_BITWIDTH:0] s;
        s = {a[ACC_BITWIDTH-1], a} + {b[ACC_BITWIDTH-1], b};
        if (s[ACC_BITWIDTH] != s[ACC_BITWIDTH-1])
            return s[ACC_BITWIDTH] ? ACC_MIN : ACC_MAX;
        return s[ACC_BITWIDTH-1:0];
    endfunction

endpackage

// File: rtl/requant_lane.sv
// Combinational requantisation of one accumulator lane: optional ReLU,
// round-half-up arithmetic right shift, saturation to activation width.
module requant_lane
    import psum_accumulator_pkg::*;
(
    input  acc_t       acc,
    input  logic [4:0] shift,
    input  logic       relu,
    output act_t       act
);

    localparam int W = ACC_BITWIDTH + 1;
    typedef logic signed [W-1:0] wide_t;

    localparam wide_t ACT_MAX = wide_t'(2**(A_BITWIDTH-1) - 1);
    localparam wide_t ACT_MIN = wide_t'(-(2**(A_BITWIDTH-1)));

    wide_t clamped;
    wide_t half;
    wide_t rounded;
    wide_t shifted;

    always_comb begin
        clamped = (relu && acc[ACC_BITWIDTH-1]) ? '0 : wide_t'(acc);
        // Half LSB of the shifted result; collapses to zero when shift is 0.
        half    = (wide_t'(1) << shift) >>> 1;
        rounded = clamped + half;
        shifted = rounded >>> shift;
        if (shifted > ACT_MAX)
            act = ACT_MAX[A_BITWIDTH-1:0];
        else if (shifted < ACT_MIN)
            act = ACT_MIN[A_BITWIDTH-1:0];
        else
            act = shifted[A_BITWIDTH-1:0];
    end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates per-column partial sums across K-tiles into a row buffer and
// streams requantised rows out on the last K-tile.
module psum_accumulator
    import psum_accumulator_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ROWS_W-1:0] cfg_rows,
    input  logic [4:0]        cfg_shift,
    input  logic              cfg_relu,
    input  logic              in_valid,
    output logic              in_ready,
    input  psum_row_t         in_data,
    input  logic              in_first,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output act_row_t          out_data,
    output logic [ROW_W-1:0]  out_row,
    output logic              tile_done
);

    acc_row_t          row_buf [ACC_DEPTH];
    logic [ROW_W-1:0]  row_ptr;
    logic [ROWS_W-1:0] rows_eff;
    logic              last_row;
    logic              accept;
    logic              idle;
    acc_row_t          sum_row;
    act_row_t          post_row;

    assign rows_eff = (cfg_rows == '0 || cfg_rows > ROWS_W'(ACC_DEPTH))
                      ? ROWS_W'(ACC_DEPTH) : cfg_rows;
    assign last_row = (ROWS_W'(row_ptr) == rows_eff - ROWS_W'(1));
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign idle     = (row_ptr == '0) && !out_valid;

    // Read-modify-write of the current row happens within the accept cycle.
    always_comb begin
        sum_row = '0;
        for (int c = 0; c < SYS_COLS; c++) begin
            if (in_first)
                sum_row[c] = sext_psum(in_data[c]);
            else
                sum_row[c] = sat_add(row_buf[row_ptr][c], sext_psum(in_data[c]));
        end
    end

    for (genvar c = 0; c < SYS_COLS; c++) begin : g_lane
        requant_lane u_requant (
            .acc   (sum_row[c]),
            .shift (cfg_shift),
            .relu  (cfg_relu),
            .act   (post_row[c])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_ptr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            tile_done <= 1'b0;
            for (int r = 0; r < ACC_DEPTH; r++)
                row_buf[r] <= '0;
        end else begin
            tile_done <= accept && in_last && last_row;
            if (accept) begin
                row_buf[row_ptr] <= sum_row;
                row_ptr          <= last_row ? '0 : row_ptr + ROW_W'(1);
            end
            if (accept && in_last) begin
                out_valid <= 1'b1;
                out_data  <= post_row;
                out_row   <= row_ptr;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Configuration may only move while no tile is in flight.
    cfg_stable_when_busy : assert property (
        @(posedge clk) disable iff (!rst)
        !idle |-> $stable({cfg_rows, cfg_shift, cfg_relu})
    );

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator: directed scenarios plus random tiles
// checked against an integer reference model of accumulate/requantise.
module tb_psum_accumulator;
    import psum_accumulator_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [ROWS_W-1:0] cfg_rows;
    logic [4:0]        cfg_shift;
    logic              cfg_relu;
    logic              in_valid;
    logic              in_ready;
    psum_row_t         in_data;
    logic              in_first;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    act_row_t          out_data;
    logic [ROW_W-1:0]  out_row;
    logic              tile_done;

    psum_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_rows  (cfg_rows),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .tile_done (tile_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ROW_W-1:0] row;
        act_row_t         data;
    } exp_t;

    exp_t   exp_q[$];
    longint m_buf [ACC_DEPTH][SYS_COLS];
    int     m_ptr;
    bit     td_exp;
    int     bp_mode;       // 0: always ready, 1: random, 2: stalled
    int     vectors;
    int     miscompares;

    localparam int     MAXI    = 32'h7fffffff;
    localparam int     MINI    = 32'h80000000;
    localparam longint ACC_HI  = (longint'(1) << (ACC_BITWIDTH-1)) - 1;
    localparam longint ACC_LO  = -(longint'(1) << (ACC_BITWIDTH-1));

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic int m_rows();
        int r = int'(cfg_rows);
        return (r == 0 || r > ACC_DEPTH) ? ACC_DEPTH : r;
    endfunction

    function automatic longint post(input longint x);
        longint xp;
        longint y;
        int     sh = int'(cfg_shift);
        xp = (cfg_relu && x < 0) ? 0 : x;
        if (sh > 0) y = (xp + (longint'(1) << (sh - 1))) >>> sh;
        else        y = xp;
        if (y > 2**(A_BITWIDTH-1) - 1) y = 2**(A_BITWIDTH-1) - 1;
        if (y < -(2**(A_BITWIDTH-1)))  y = -(2**(A_BITWIDTH-1));
        return y;
    endfunction

    task automatic model_accept(input int d0, input int d1, input int d2, input bit first, input bit last);
        int     d[SYS_COLS];
        int     rows;
        int     r;
        longint s;
        exp_t   e;
        d[0] = d0; d[1] = d1; d[2] = d2;
        rows = m_rows();
        r    = m_ptr;
        e.row  = r[ROW_W-1:0];
        e.data = '0;
        for (int c = 0; c < SYS_COLS; c++) begin
            s = first ? longint'(d[c]) : m_buf[r][c] + longint'(d[c]);
            if (s > ACC_HI) s = ACC_HI;
            if (s < ACC_LO) s = ACC_LO;
            m_buf[r][c] = s;
            e.data[c] = A_BITWIDTH'(post(s));
        end
        if (last) exp_q.push_back(e);
        td_exp = last && (r == rows - 1);
        m_ptr  = (r == rows - 1) ? 0 : r + 1;
    endtask

    task automatic model_reset();
        for (int r = 0; r < ACC_DEPTH; r++)
            for (int c = 0; c < SYS_COLS; c++)
                m_buf[r][c] = 0;
        m_ptr = 0;
        exp_q.delete();
        td_exp = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic send_row(input int d0, input int d1, input int d2, input bit first, input bit last);
        int n = 0;
        in_valid   = 1'b1;
        in_data[0] = d0;
        in_data[1] = d1;
        in_data[2] = d2;
        in_first   = first;
        in_last    = last;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: in_ready stuck at 0 after %0d cycles", n);
        end else begin
            model_accept(d0, d1, d2, first, last);
        end
        @(negedge clk);
    endtask

    task automatic go_idle();
        int n = 0;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        bp_mode  = 0;
        while ((out_valid || exp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (out_valid || exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: out_valid %0b, %0d rows still expected", out_valid, exp_q.size());
        end
        @(negedge clk);
    endtask

    function automatic int rnd_val();
        case ($urandom_range(0, 2))
            0:       return $urandom_range(0, 400) - 200;
            1:       return int'($urandom());
            default: return ($urandom_range(0, 1) == 1) ? MAXI : MINI;
        endcase
    endfunction

    // Output monitor: chooses out_ready for the coming edge, then pops on handshake.
    initial begin
        exp_t e;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b0;
            endcase
            if (rst === 1'b1 && out_valid === 1'b1 && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_output: got row %0d data %h, expected none", out_row, out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_row", 64'(out_row), 64'(e.row));
                    check("out_data", 64'(out_data), 64'(e.data));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("tile_done", 64'(tile_done), 64'(td_exp));
            td_exp = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        bp_mode     = 0;
        model_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        cfg_rows  = ROWS_W'(2);
        cfg_shift = 5'd0;
        cfg_relu  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_out_row", 64'(out_row), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Single-tile pass-through with saturation on row 1.
        send_row(5, -3, 127, 1'b1, 1'b1);
        send_row(200, -200, 0, 1'b1, 1'b1);
        go_idle();

        // Three K-tiles into one row; only the last emits.
        cfg_rows  = ROWS_W'(1);
        cfg_shift = 5'd2;
        send_row(10, 0, 0, 1'b1, 1'b0);
        check("no_emit_first", 64'(out_valid), 64'd0);
        send_row(20, 0, 0, 1'b0, 1'b0);
        check("no_emit_mid", 64'(out_valid), 64'd0);
        send_row(7, 0, 0, 1'b0, 1'b1);
        go_idle();

        // ReLU and rounding, both polarities of relu.
        cfg_shift = 5'd1;
        cfg_relu  = 1'b1;
        send_row(-9, 3, 255, 1'b1, 1'b1);
        go_idle();
        cfg_relu = 1'b0;
        send_row(-9, 3, 255, 1'b1, 1'b1);
        go_idle();

        // Backpressure: stalled output blocks input and holds out_data.
        cfg_rows  = ROWS_W'(4);
        cfg_shift = 5'd0;
        bp_mode   = 2;
        send_row(11, 22, 33, 1'b1, 1'b1);
        in_data[0] = 44; in_data[1] = 55; in_data[2] = 66;
        in_valid = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_data", 64'(out_data), {40'd0, 8'd33, 8'd22, 8'd11});
            @(negedge clk);
            #1;
        end
        bp_mode = 0;
        send_row(44, 55, 66, 1'b1, 1'b1);
        send_row(1, 2, 3, 1'b1, 1'b1);
        send_row(4, 5, 6, 1'b1, 1'b1);
        go_idle();

        // Four full-depth K-tiles of max psum in lane 0: 4*(2^31-1) must not wrap.
        cfg_rows  = ROWS_W'(16);
        cfg_shift = 5'd31;
        for (int k = 0; k < 4; k++)
            for (int r = 0; r < 16; r++)
                send_row(MAXI, rnd_val(), rnd_val(), k == 0, k == 3);
        go_idle();

        // Drive the accumulator into both saturation rails.
        cfg_rows  = ROWS_W'(1);
        cfg_shift = 5'd0;
        send_row(MAXI, MINI, 0, 1'b1, 1'b0);
        for (int k = 0; k < 256; k++)
            send_row(MAXI, MINI, 0, 1'b0, 1'b0);
        send_row(1, -1, 0, 1'b0, 1'b1);
        go_idle();

        // Asynchronous reset with an output pending mid-tile.
        cfg_rows = ROWS_W'(8);
        send_row(rnd_val(), rnd_val(), rnd_val(), 1'b1, 1'b0);
        send_row(rnd_val(), rnd_val(), rnd_val(), 1'b1, 1'b0);
        bp_mode = 2;
        send_row(1, 2, 3, 1'b1, 1'b1);
        #1;
        check("pre_reset_out_valid", 64'(out_valid), 64'd1);
        rst = 1'b0;
        #1;
        check("async_reset_out_valid", 64'(out_valid), 64'd0);
        check("async_reset_in_ready", 64'(in_ready), 64'd1);
        model_reset();
        in_valid = 1'b0;
        bp_mode  = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 8; r++)
            send_row(rnd_val(), rnd_val(), rnd_val(), 1'b1, 1'b1);
        go_idle();

        // Random configurations and tiles under random backpressure.
        for (int t = 0; t < 12; t++) begin
            int kt;
            cfg_rows  = ROWS_W'($urandom_range(0, 31));
            cfg_shift = 5'($urandom_range(0, 31));
            cfg_relu  = 1'($urandom_range(0, 1));
            kt        = $urandom_range(1, 3);
            bp_mode   = 1;
            for (int k = 0; k < kt; k++)
                for (int r = 0; r < m_rows(); r++)
                    send_row(rnd_val(), rnd_val(), rnd_val(), k == 0, k == kt - 1);
            go_idle();
        end

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Downstream stage of the systolic array top: consumes the per-column partial-sum vector `result` qualified by `ready`.
- Accumulates partial sums across K-tiles into a row buffer, indexed by output row.
- On the last K-tile it post-processes each row (optional ReLU, rounding right-shift, saturation to activation width) and emits it on a valid/ready stream to the activation writeback.
- Shared constants come from the `Config` package.

Parameters:
- SYS_COLS, sys_cols (3), number of array columns / lanes per row.
- P_BITWIDTH, P_BITWIDTH (32), signed width of incoming partial sums.
- ACC_BITWIDTH, P_BITWIDTH+8 (40), signed accumulator width.
- A_BITWIDTH, 8, signed output activation width.
- ACC_DEPTH, 16, number of rows held in the buffer.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- cfg_rows  in  $clog2(ACC_DEPTH+1)  rows per tile, legal range 1..ACC_DEPTH; sampled only when idle.
- cfg_shift  in  5  right-shift amount applied to the accumulator, 0..31.
- cfg_relu  in  1  when 1, clamp negative results to 0 before the shift.
- in_valid  in  1  partial-sum row valid; driven from top `ready`.
- in_ready  out  1  row accepted when in_valid & in_ready.
- in_data  in  SYS_COLS*P_BITWIDTH  packed [SYS_COLS-1:0][P_BITWIDTH-1:0] signed partial sums.
- in_first  in  1  current K-tile is the first: overwrite instead of add.
- in_last  in  1  current K-tile is the last: emit the post-processed row.
- out_valid  out  1  output row valid.
- out_ready  in  1  downstream accepts the output row.
- out_data  out  SYS_COLS*A_BITWIDTH  packed activations.
- out_row  out  $clog2(ACC_DEPTH)  row index of out_data.
- tile_done  out  1  one-cycle pulse when the final row of an in_last tile is accepted.

Behaviour:
- Reset (rst=0, async):
  - row_ptr=0, all buffer entries=0.
  - out_valid=0, out_data=0, out_row=0, tile_done=0.
  - in_ready=1 after reset release.
- in_ready = !out_valid | out_ready. Single output register; no skid.
- On accept, with row = row_ptr, operating per lane c:
  - in_first=1: sum = sext(in_data[c]).
  - in_first=0: sum = buf[row][c] + sext(in_data[c]), saturated to signed ACC_BITWIDTH (no wrap).
  - buf[row][c] <= sum in the same cycle (zero-latency read-modify-write; register array, combinational read).
  - row_ptr <= (row_ptr == cfg_rows-1) ? 0 : row_ptr+1.
- in_first=1 and in_last=1 together is legal (single K-tile): write the input and emit it.
- Emit (in_last=1 on accept): at the next edge out_valid=1, out_row=row, out_data[c]=post(sum[c]). Latency is 1 cycle from accept.
- post(x):
  - x' = (cfg_relu & x<0) ? 0 : x.
  - If cfg_shift>0: y = (x' + (1<<(cfg_shift-1))) >>> cfg_shift. Round half up; arithmetic shift; intermediate is ACC_BITWIDTH+1 bits.
  - If cfg_shift=0: y = x'.
  - Saturate y to [-2^(A_BITWIDTH-1), 2^(A_BITWIDTH-1)-1].
- out_valid falls when out_ready=1 and no new emit occurs that cycle.
- Simultaneous pop and new emit: out_data/out_row are replaced and out_valid stays 1.
- out_valid=1 & out_ready=0: in_ready=0, so no row is accepted and the buffer and row_ptr hold.
- tile_done=1 for exactly one cycle, on the cycle after accepting row cfg_rows-1 with in_last=1.
- Idle means row_ptr==0 & !out_valid. Changing cfg_* outside idle is illegal; the behaviour is undefined, and the assertion must flag it.
- cfg_rows=0 or cfg_rows>ACC_DEPTH is treated as ACC_DEPTH.
- Reset asserted mid-tile: all state is cleared immediately; any pending output is dropped.

Decomposition:
- Config additions: A_BITWIDTH, ACC_BITWIDTH, ACC_DEPTH; typedefs `acc_t` (signed ACC_BITWIDTH) and `act_t` (signed A_BITWIDTH); packed row types `psum_row_t`, `acc_row_t`, `act_row_t`.
- Sub-module `requant_lane`: purely combinational ReLU, round-shift and saturate for one lane, instantiated SYS_COLS times.
- Saturating add stays inline.

Test Plan:
- Single-tile pass-through: cfg_rows=2, shift=0, relu=0; rows {5,-3,127} and {200,-200,0} with first=last=1 -> out {5,-3,127} row0, then {127,-128,0} row1; tile_done pulse after row1.
- Three-tile accumulate: cfg_rows=1, shift=2; lane0 inputs 10, 20, 7 (first/mid/last) -> only one output; lane0 = (37+2)>>>2 = 9; no out_valid on the first two accepts.
- ReLU and rounding: shift=1, relu=1, last-tile sums {-9, 3, 255} -> {0, 2, 127}; with relu=0 -> {-4, 2, 127}.
- Backpressure: hold out_ready=0 after an emit while in_valid=1 -> in_ready=0, row_ptr and buffer unchanged, out_data stable; release out_ready -> next row is accepted that cycle and the output updates one cycle later.
- Accumulator saturation and wrap-around: cfg_rows=16, four K-tiles of 2^31-1 in lane0 -> buffer holds 4*(2^31-1) without overflow; then force 2^39-1 plus 1 -> stays 2^39-1; row_ptr returns to 0 after row 15 in each tile.
- Reset mid-tile: assert rst low after 3 of 8 rows with out_valid=1 -> out_valid=0 immediately (async); after release a first=last pass with 8 rows emits out_row 0..7 in order.
